// File: rtl/dzcpu_ucode_seq_if.sv
// Fetch/host-side bundle for the dzcpu microcode sequencer: opcode handshake,
// table programming port and the decoded micro-op stream toward the datapath.
interface dzcpu_ucode_seq_if #(
    parameter int UOP_W     = 13,
    parameter int UADDR_W   = 8,
    parameter int NUM_PAGES = 2
);
    localparam int SEL_W = $clog2(NUM_PAGES + 1);
    localparam int TA_W  = (UADDR_W > 8) ? UADDR_W : 8;

    logic [7:0]       iMop;
    logic             iMopValid;
    logic             oMopReady;
    logic             iFlagZ;
    logic             iStall;
    logic             iTblWe;
    logic [SEL_W-1:0] iTblSel;
    logic [TA_W-1:0]  iTblAddr;
    logic [UOP_W-1:0] iTblData;
    logic [UOP_W-1:0] oUop;
    logic             oUopValid;
    logic             oIncPc;
    logic             oEof;
    logic             oUpdateFlags;
    logic             oFault;

    modport master (
        output iMop, iMopValid, iFlagZ, iStall, iTblWe, iTblSel, iTblAddr, iTblData,
        input  oMopReady, oUop, oUopValid, oIncPc, oEof, oUpdateFlags, oFault
    );

    modport slave (
        input  iMop, iMopValid, iFlagZ, iStall, iTblWe, iTblSel, iTblAddr, iTblData,
        output oMopReady, oUop, oUopValid, oIncPc, oEof, oUpdateFlags, oFault
    );
endinterface

// File: rtl/dzcpu_ucode_seq.sv
// Writable microcode sequencer: RAM dispatch pages map opcodes to micro-addresses,
// a RAM micro-op store feeds the datapath one micro-op per non-stalled cycle.
module dzcpu_ucode_seq #(
    parameter int UOP_W     = 13,
    parameter int CTL_W     = 4,
    parameter int UADDR_W   = 8,
    parameter int NUM_PAGES = 2
) (
    input  logic              iClock,
    input  logic              iReset,
    dzcpu_ucode_seq_if.slave  bus
);
    localparam int SEL_W  = $clog2(NUM_PAGES + 1);
    localparam int PAGE_W = (NUM_PAGES > 1) ? $clog2(NUM_PAGES) : 1;
    localparam int DISP_D = (2 ** PAGE_W) * 256;

    localparam logic [CTL_W-1:0] C_INC        = CTL_W'(1);
    localparam logic [CTL_W-1:0] C_EOF        = CTL_W'(2);
    localparam logic [CTL_W-1:0] C_INC_EOF    = CTL_W'(3);
    localparam logic [CTL_W-1:0] C_EOF_FU     = CTL_W'(4);
    localparam logic [CTL_W-1:0] C_INC_EOF_FU = CTL_W'(5);
    localparam logic [CTL_W-1:0] C_INC_EOF_Z  = CTL_W'(6);
    localparam logic [CTL_W-1:0] C_INC_EOF_NZ = CTL_W'(7);
    localparam logic [CTL_W-1:0] C_JCB        = CTL_W'(8);
    localparam logic [CTL_W-1:0] C_UPD_FLAGS  = CTL_W'(9);

    typedef enum logic [2:0] {
        IDLE,
        DISPATCH,
        FETCH,
        RUN,
        PREFIX
    } state_t;

    state_t              state;
    logic [PAGE_W-1:0]   page;
    logic [7:0]          mop;
    logic [UADDR_W-1:0]  uaddr;
    logic [UADDR_W-1:0]  uaddrNext;
    logic [UOP_W-1:0]    uopReg;

    logic [UADDR_W-1:0]  dispTbl [DISP_D];
    logic [UOP_W-1:0]    store   [2 ** UADDR_W];
    logic [PAGE_W+7:0]   wrIdx;

    logic [CTL_W-1:0]    ctl;
    logic                isInc;
    logic                isFu;
    logic                isTerm;
    logic                isJcb;
    logic                overrun;
    logic                issue;

    assign uaddrNext = uaddr + UADDR_W'(1);
    assign wrIdx     = {bus.iTblSel[PAGE_W-1:0], bus.iTblAddr[7:0]};

    // Dispatch pages are cleared on reset so unprogrammed opcodes fall back to flow 0.
    always_ff @(posedge iClock) begin
        if (iReset) begin
            for (int i = 0; i < DISP_D; i++) begin
                dispTbl[i] <= '0;
            end
        end else if (bus.iTblWe && (bus.iTblSel < SEL_W'(NUM_PAGES))) begin
            dispTbl[wrIdx] <= bus.iTblData[UADDR_W-1:0];
        end
    end

    // The micro-op store keeps its contents across reset.
    always_ff @(posedge iClock) begin
        if (bus.iTblWe && (bus.iTblSel == SEL_W'(NUM_PAGES))) begin
            store[bus.iTblAddr[UADDR_W-1:0]] <= bus.iTblData;
        end
    end

    // Decode of the micro-op currently presented; jcb at the last address re-dispatches rather than faulting.
    always_comb begin
        ctl     = uopReg[UOP_W-1 -: CTL_W];
        isInc   = ctl inside {C_INC, C_INC_EOF, C_INC_EOF_FU, C_INC_EOF_Z, C_INC_EOF_NZ};
        isFu    = ctl inside {C_EOF_FU, C_INC_EOF_FU, C_UPD_FLAGS};
        isJcb   = (ctl == C_JCB);
        isTerm  = (ctl inside {C_EOF, C_INC_EOF, C_EOF_FU, C_INC_EOF_FU})
               || ((ctl == C_INC_EOF_Z)  &&  bus.iFlagZ)
               || ((ctl == C_INC_EOF_NZ) && !bus.iFlagZ);
        overrun = !isTerm && !isJcb && (uaddr == '1);
        issue   = (state == RUN) && !bus.iStall;
    end

    // Sequencing FSM; in RUN the store is read at the next address so issue has no bubble.
    always_ff @(posedge iClock) begin
        if (iReset) begin
            state  <= IDLE;
            page   <= '0;
            mop    <= '0;
            uaddr  <= '0;
            uopReg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.iMopValid) begin
                        mop   <= bus.iMop;
                        page  <= '0;
                        state <= DISPATCH;
                    end
                end
                DISPATCH: begin
                    uaddr <= dispTbl[{page, mop}];
                    state <= FETCH;
                end
                FETCH: begin
                    uopReg <= store[uaddr];
                    state  <= RUN;
                end
                RUN: begin
                    if (!bus.iStall) begin
                        if (isTerm || overrun) begin
                            state <= IDLE;
                        end else if (isJcb) begin
                            state <= PREFIX;
                        end else begin
                            uaddr  <= uaddrNext;
                            uopReg <= store[uaddrNext];
                        end
                    end
                end
                PREFIX: begin
                    if (bus.iMopValid) begin
                        mop   <= bus.iMop;
                        page  <= PAGE_W'(1);
                        state <= DISPATCH;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.oMopReady    = (state == IDLE) || (state == PREFIX);
    assign bus.oUop         = uopReg;
    assign bus.oUopValid    = (state == RUN);
    assign bus.oIncPc       = issue && isInc;
    assign bus.oEof         = issue && (isTerm || overrun);
    assign bus.oFault       = issue && overrun;
    assign bus.oUpdateFlags = (state == RUN) && isFu;
endmodule
